// File: rtl/eth_tx_framer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// eth_tx_framer
//
// Purpose:
//   Takes a byte-wide AXI-stream Ethernet frame (dst MAC .. FCS, FCS already
//   appended) and turns it into a wire-ready byte stream: PREAMBLE_BYTES x 0x55,
//   one 0xD5 SFD, the frame bytes passed straight through with backpressure,
//   then an inter-frame gap before the next frame is accepted. Frames shorter
//   than MIN_FRAME_BYTES raise a one-cycle runt pulse.
//
// Parameters:
//   DATA_WIDTH      stream byte width (only 8 is supported)
//   PREAMBLE_BYTES  number of 0x55 bytes ahead of the SFD (1..15)
//   IFG_CYCLES      idle wire cycles after the last frame byte (1..255)
//   MIN_FRAME_BYTES minimum frame length incl. FCS used for runt detection
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tlast/s_tready   upstream frame stream (sink side)
//   m_tdata/m_tvalid/m_tlast/m_tready   wire byte stream (source side)
//   m_tuser               high on the first preamble byte
//   busy                  block is not idle
//   runt                  one-cycle pulse: completed frame was too short
//
// Optional build macro ETH_TX_FRAMER_STATS_EN adds free-running counters:
//   stat_frames (32b) completed frames, stat_bytes (32b) frame bytes passed,
//   stat_runts (16b) runt frames. All wrap, reset only by rst_n.
// -----------------------------------------------------------------------------
module eth_tx_framer #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned PREAMBLE_BYTES  = 7,
    parameter int unsigned IFG_CYCLES      = 12,
    parameter int unsigned MIN_FRAME_BYTES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic                  m_tuser,
    input  logic                  m_tready,
    output logic                  busy,
    output logic                  runt
`ifdef ETH_TX_FRAMER_STATS_EN
    ,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_bytes,
    output logic [15:0]           stat_runts
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_IFG      = 3'd4
    } state_t;

    localparam logic [DATA_WIDTH-1:0] PRE_BYTE = DATA_WIDTH'(8'h55);
    localparam logic [DATA_WIDTH-1:0] SFD_BYTE = DATA_WIDTH'(8'hD5);
    localparam logic [3:0]            PRE_LAST = 4'(PREAMBLE_BYTES - 1);
    localparam logic [16:0]           MIN_LEN  = 17'(MIN_FRAME_BYTES);

    // The IDLE cycle that follows the gap is itself an idle wire cycle, so the
    // IFG state only covers IFG_CYCLES-1 clocks. This keeps exactly IFG_CYCLES
    // idle cycles on the wire and puts the next m_tuser IFG_CYCLES+1 cycles
    // after tlast. With IFG_CYCLES==1 the IFG state is skipped altogether.
    localparam bit                    SKIP_IFG = (IFG_CYCLES == 1);
    localparam logic [7:0]            GAP_LAST = 8'(IFG_CYCLES - 2);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_pre_cnt;
    logic [15:0]   r_frame_cnt;
    logic [7:0]    r_gap_cnt;
    logic          r_runt;

    logic          w_xfer;
    logic          w_last_xfer;
    logic [16:0]   w_frame_len;
    logic          w_is_runt;

    // Frame byte handshake, only meaningful while passing data through
    assign w_xfer      = (r_state == ST_DATA) && s_tvalid && m_tready;
    assign w_last_xfer = w_xfer && s_tlast;

    // Length the frame will have once the current byte is counted
    assign w_frame_len = {1'b0, r_frame_cnt} + 17'd1;
    assign w_is_runt   = (w_frame_len < MIN_LEN);

    assign busy = (r_state != ST_IDLE);
    assign runt = r_runt;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs. s_tready depends only on state and m_tready so
    // that the upstream's tvalid (which may depend on tready) cannot loop.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        s_tready    = 1'b0;
        m_tdata     = '0;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        m_tuser     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (s_tvalid) begin
                    w_state_nxt = ST_PREAMBLE;
                end
            end

            ST_PREAMBLE: begin
                m_tvalid = 1'b1;
                m_tdata  = PRE_BYTE;
                m_tuser  = (r_pre_cnt == 4'd0);
                if (m_tready && (r_pre_cnt == PRE_LAST)) begin
                    w_state_nxt = ST_SFD;
                end
            end

            ST_SFD: begin
                m_tvalid = 1'b1;
                m_tdata  = SFD_BYTE;
                if (m_tready) begin
                    w_state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                m_tdata  = s_tdata;
                m_tvalid = s_tvalid;
                m_tlast  = s_tlast;
                s_tready = m_tready;
                if (w_last_xfer) begin
                    w_state_nxt = SKIP_IFG ? ST_IDLE : ST_IFG;
                end
            end

            ST_IFG: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Preamble byte counter: advances per accepted preamble byte, frozen while
    // m_tready is low, cleared outside the preamble.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (r_state == ST_PREAMBLE) begin
            if (m_tready) begin
                r_pre_cnt <= (r_pre_cnt == PRE_LAST) ? 4'd0 : r_pre_cnt + 4'd1;
            end
        end else begin
            r_pre_cnt <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Frame byte counter: cleared as the SFD leaves, saturating at 0xFFFF so a
    // jumbo frame can never wrap back into the runt range.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if ((r_state == ST_SFD) && m_tready) begin
            r_frame_cnt <= '0;
        end else if (w_xfer && (r_frame_cnt != 16'hFFFF)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Gap counter: counts every clock in the gap regardless of m_tready
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt <= '0;
        end else if (r_state == ST_IFG) begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
        end else begin
            r_gap_cnt <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Runt pulse, one cycle after the tlast transfer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_runt <= 1'b0;
        end else begin
            r_runt <= w_last_xfer && w_is_runt;
        end
    end

`ifdef ETH_TX_FRAMER_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics counters (wrap modulo their width)
    // -------------------------------------------------------------------------
    logic [31:0] r_stat_frames;
    logic [31:0] r_stat_bytes;
    logic [15:0] r_stat_runts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_frames <= '0;
            r_stat_bytes  <= '0;
            r_stat_runts  <= '0;
        end else begin
            if (w_xfer) begin
                r_stat_bytes <= r_stat_bytes + 32'd1;
            end
            if (w_last_xfer) begin
                r_stat_frames <= r_stat_frames + 32'd1;
            end
            if (w_last_xfer && w_is_runt) begin
                r_stat_runts <= r_stat_runts + 16'd1;
            end
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_bytes  = r_stat_bytes;
    assign stat_runts  = r_stat_runts;
`endif

endmodule

// File: tb/tb_eth_tx_framer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_eth_tx_framer
//
// Directed bench for eth_tx_framer: an upstream byte source task, a negedge
// monitor logging every wire transfer, a m_tready stall generator, and
// expected frames rebuilt from the preamble/SFD/data layout.
// -----------------------------------------------------------------------------
module tb_eth_tx_framer;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [7:0]  s_tdata  = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast  = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;
    logic        m_tready = 1'b1;
    logic        busy;
    logic        runt;
`ifdef ETH_TX_FRAMER_STATS_EN
    logic [31:0] stat_frames;
    logic [31:0] stat_bytes;
    logic [15:0] stat_runts;
`endif

    eth_tx_framer #(
        .DATA_WIDTH      (8),
        .PREAMBLE_BYTES  (7),
        .IFG_CYCLES      (12),
        .MIN_FRAME_BYTES (64)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser),
        .m_tready (m_tready),
        .busy     (busy),
        .runt     (runt)
`ifdef ETH_TX_FRAMER_STATS_EN
        ,
        .stat_frames (stat_frames),
        .stat_bytes  (stat_bytes),
        .stat_runts  (stat_runts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       u;
        logic       l;
        int         c;
    } beat_t;

    beat_t obs_q[$];
    int    runt_q[$];
    int    acc_q[$];
    int    cyc        = 0;
    int    out_idx    = 0;
    int    hold_cnt   = 0;
    int    stall_seen = 0;
    int    hold_err   = 0;
    bit    stall_mode = 1'b0;
    bit    prev_stall = 1'b0;
    logic [7:0] prev_d = '0;

    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc++;

    // Monitor: log wire transfers, upstream accepts, runt pulses, stall holds
    always @(negedge clk) begin
        if (!rst_n) begin
            out_idx    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(m_tvalid && (m_tdata == prev_d))) hold_err++;
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            if (m_tvalid && !m_tready) stall_seen++;
            if (m_tvalid && m_tready) begin
                obs_q.push_back('{d: m_tdata, u: m_tuser, l: m_tlast, c: cyc});
                out_idx = m_tlast ? 0 : out_idx + 1;
            end
            if (s_tvalid && s_tready) acc_q.push_back(cyc);
            if (runt) runt_q.push_back(cyc);
        end
    end

    // m_tready: in stall mode hold low 3 cycles at output byte 4 (preamble
    // byte 4) and output byte 18 (data byte 10)
    always @(posedge clk) begin
        #1;
        if (stall_mode && (out_idx == 4 || out_idx == 18) && hold_cnt < 3) begin
            m_tready = 1'b0;
            hold_cnt++;
        end else begin
            m_tready = 1'b1;
            if (!(out_idx == 4 || out_idx == 18)) hold_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Upstream source: bytes idx[7:0], optional s_tvalid gap before byte
    // gap_at, optional reset while byte abort_at is presented.
    task automatic send_frame(input int len, input int gap_at, input int gap_len,
                              input int abort_at, input bit keep_valid);
        int idx   = 0;
        int gaps  = 0;
        int guard = 0;
        bit acc;
        while (idx < len) begin
            if (idx == gap_at && gaps < gap_len) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                gaps++;
            end else begin
                s_tvalid = 1'b1;
                s_tdata  = 8'(idx);
                s_tlast  = (idx == len - 1);
            end
            if (idx == abort_at) begin
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                return;
            end
            @(negedge clk);
            acc = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
            if (guard >= 2000) begin
                chk("src_timeout", 32'(idx), 32'(len));
                break;
            end
        end
        if (!keep_valid) begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    // Expected wire frame: 7 x 55 (tuser on first), D5, bytes 0..len-1 (tlast)
    task automatic check_frame(input int base, input int len, input string tag);
        for (int i = 0; i < len + 8; i++) begin
            logic [7:0] ed;
            logic       eu;
            logic       el;
            beat_t      b;
            if (base + i >= obs_q.size()) begin
                chk({tag, "_count"}, 32'(obs_q.size() - base), 32'(len + 8));
                return;
            end
            b  = obs_q[base + i];
            eu = 1'b0;
            el = 1'b0;
            if (i < 7) begin
                ed = 8'h55;
                eu = (i == 0);
            end else if (i == 7) begin
                ed = 8'hD5;
            end else begin
                ed = 8'(i - 8);
                el = (i - 8 == len - 1);
            end
            chk($sformatf("%s_b%0d", tag, i), {22'd0, b.u, b.l, b.d}, {22'd0, eu, el, ed});
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
        chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_m_tdata"},  32'(m_tdata),  32'd0);
        chk({tag, "_m_tlast"},  32'(m_tlast),  32'd0);
        chk({tag, "_m_tuser"},  32'(m_tuser),  32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_runt"},     32'(runt),     32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rbase;
        int abase;
        int sbase;
        int hbase;
        int c0;
        int t_last;
        int n_in_gap;

        // Reset state
        #12;
        check_idle_outputs("rst");
`ifdef ETH_TX_FRAMER_STATS_EN
        chk("rst_stat_frames", stat_frames, 32'd0);
        chk("rst_stat_bytes",  stat_bytes,  32'd0);
        chk("rst_stat_runts",  32'(stat_runts), 32'd0);
`endif

        // 64-byte frame, no stalls
        apply_reset();
        base  = obs_q.size();
        rbase = runt_q.size();
        c0    = cyc;
        send_frame(64, -1, 0, -1, 1'b0);
        check_frame(base, 64, "f64");
        chk("f64_latency", 32'(obs_q[base].c - c0), 32'd1);
        t_last = obs_q[base + 71].c;
        wait_neg(t_last + 11);
        chk("f64_busy_in_gap", 32'(busy), 32'd1);
        wait_neg(t_last + 12);
        chk("f64_busy_after_gap", 32'(busy), 32'd0);
        chk("f64_no_runt", 32'(runt_q.size() - rbase), 32'd0);

        // 60-byte runt frame
        apply_reset();
        base  = obs_q.size();
        rbase = runt_q.size();
        send_frame(60, -1, 0, -1, 1'b0);
        check_frame(base, 60, "f60");
        t_last = obs_q[base + 67].c;
        wait_neg(t_last + 4);
        chk("f60_runt_pulses", 32'(runt_q.size() - rbase), 32'd1);
        chk("f60_runt_cycle", 32'(runt_q[rbase] - t_last), 32'd1);
`ifdef ETH_TX_FRAMER_STATS_EN
        chk("f60_stat_frames", stat_frames, 32'd1);
        chk("f60_stat_runts",  32'(stat_runts), 32'd1);
        chk("f60_stat_bytes",  stat_bytes,  32'd60);
`endif

        // Back-to-back frames with s_tvalid held high
        apply_reset();
        base  = obs_q.size();
        abase = acc_q.size();
        send_frame(64, -1, 0, -1, 1'b1);
        send_frame(64, -1, 0, -1, 1'b0);
        wait_neg(cyc + 2);
        check_frame(base, 64, "b2b1");
        check_frame(base + 72, 64, "b2b2");
        t_last = obs_q[base + 71].c;
        chk("b2b_spacing", 32'(obs_q[base + 72].c - t_last), 32'd13);
        n_in_gap = 0;
        for (int i = abase; i < acc_q.size(); i++) begin
            if (acc_q[i] > t_last && acc_q[i] <= t_last + 20) n_in_gap++;
        end
        chk("b2b_accept_in_gap", 32'(n_in_gap), 32'd0);
        chk("b2b_accept_total", 32'(acc_q.size() - abase), 32'd128);

        // m_tready stalls at preamble byte 4 and data byte 10
        apply_reset();
        base  = obs_q.size();
        sbase = stall_seen;
        hbase = hold_err;
        stall_mode = 1'b1;
        send_frame(64, -1, 0, -1, 1'b0);
        wait_neg(cyc + 2);
        stall_mode = 1'b0;
        check_frame(base, 64, "stall");
        chk("stall_cycles", 32'(stall_seen - sbase), 32'd6);
        chk("stall_hold_err", 32'(hold_err - hbase), 32'd0);

        // 63-byte frame with a 5-cycle s_tvalid gap before byte 30
        apply_reset();
        base  = obs_q.size();
        rbase = runt_q.size();
        send_frame(63, 30, 5, -1, 1'b0);
        wait_neg(cyc + 3);
        check_frame(base, 63, "gap");
        chk("gap_wire_spacing", 32'(obs_q[base + 38].c - obs_q[base + 37].c), 32'd6);
        chk("gap_runt_pulses", 32'(runt_q.size() - rbase), 32'd1);
`ifdef ETH_TX_FRAMER_STATS_EN
        chk("gap_stat_bytes",  stat_bytes,  32'd63);
        chk("gap_stat_frames", stat_frames, 32'd1);
`endif

        // Reset while data byte 20 is on the wire
        apply_reset();
        send_frame(64, -1, 0, 20, 1'b0);
        chk("abort_at_byte", 32'(obs_q[obs_q.size() - 1].d), 32'd20);
        check_idle_outputs("abort");
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = obs_q.size();
        send_frame(64, -1, 0, -1, 1'b0);
        check_frame(base, 64, "post_rst");
`ifdef ETH_TX_FRAMER_STATS_EN
        chk("post_rst_stat_frames", stat_frames, 32'd1);
        chk("post_rst_stat_bytes",  stat_bytes,  32'd64);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
